image_stream_tx: RTL and testbench

IMAGE_STREAM_TX -- requirements
Module: image_stream_tx

---
 rtl/cnn_pkg.sv | 14 +
 rtl/pixel_buffer.sv | 27 ++
 rtl/image_stream_tx.sv | 147 ++++++++++++++
 tb/tb_image_stream_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the CNN image streaming path: transmit FSM states and pixel word.
package cnn_pkg;

  localparam int unsigned PIXEL_BITS = 32;

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_STREAM    = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/pixel_buffer.sv
// Frame store: one synchronous write port, one combinational read port, no reset on contents.
module pixel_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned BitSize = 32,
  parameter int unsigned Depth   = 16,
  localparam int unsigned ADDR_W = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [BitSize-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [BitSize-1:0] rd_data
);

  logic [BitSize-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/image_stream_tx.sv
// Buffers one host frame and streams it to the CNN with valid/ready, then waits for the classifier.
module image_stream_tx
  import cnn_pkg::*;
#(
  parameter int unsigned BitSize    = 32,
  parameter int unsigned ImageWidth = 8
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               wr_en,
  input  logic [BitSize-1:0] wr_data,
  output logic               wr_full,
  input  logic               start,
  input  logic               abort,
  input  logic               ready_in,
  output logic               out_valid,
  output logic [BitSize-1:0] out_data,
  input  logic               result_done,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned NPix   = ImageWidth * ImageWidth;
  localparam int unsigned PTR_W  = $clog2(NPix + 1);
  localparam int unsigned ADDR_W = (NPix > 1) ? $clog2(NPix) : 1;

  tx_state_t          state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               out_valid_d;
  logic [BitSize-1:0] out_data_d;
  logic               wr_full_d;
  logic               busy_d;
  logic               frame_done_d;
  logic               buf_we_c;
  logic [ADDR_W-1:0]  rd_addr_c;
  logic [BitSize-1:0] rd_data_c;

  pixel_buffer #(
    .BitSize (BitSize),
    .Depth   (NPix)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_we_c),
    .wr_addr (ADDR_W'(wr_ptr_q)),
    .wr_data (wr_data),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data_c)
  );

  // Read address runs one pixel ahead of the presented one so each transfer reloads without a bubble.
  always_comb begin
    rd_addr_c = '0;
    if (state_q == TX_STREAM) begin
      rd_addr_c = ADDR_W'(rd_ptr_q + PTR_W'(1));
    end
  end

  // Next-state and registered-output logic; abort overrides everything else.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid;
    out_data_d   = out_data;
    frame_done_d = 1'b0;
    buf_we_c     = 1'b0;

    if (abort) begin
      state_d     = TX_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (wr_en && !wr_full) begin
            buf_we_c = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
          end
          if (start && wr_full) begin
            state_d     = TX_STREAM;
            rd_ptr_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = rd_data_c;
          end
        end
        TX_STREAM: begin
          if (out_valid && ready_in) begin
            if (rd_ptr_q == PTR_W'(NPix - 1)) begin
              state_d     = TX_WAIT_DONE;
              out_valid_d = 1'b0;
            end else begin
              rd_ptr_d   = rd_ptr_q + PTR_W'(1);
              out_data_d = rd_data_c;
            end
          end
        end
        TX_WAIT_DONE: begin
          if (result_done) begin
            state_d      = TX_IDLE;
            wr_ptr_d     = '0;
            frame_done_d = 1'b1;
          end
        end
        default: begin
          state_d     = TX_IDLE;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end

    wr_full_d = (wr_ptr_d == PTR_W'(NPix));
    busy_d    = (state_d != TX_IDLE);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      wr_full    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      wr_full    <= wr_full_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_image_stream_tx.sv
// Directed bench for image_stream_tx with a 4x4 frame of 32-bit pixels.
module tb_image_stream_tx;

  localparam int unsigned BW = 32;
  localparam int unsigned IW = 4;
  localparam int unsigned NP = IW * IW;

  logic          clk;
  logic          res_n;
  logic          wr_en;
  logic [BW-1:0] wr_data;
  logic          wr_full;
  logic          start;
  logic          abort;
  logic          ready_in;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          result_done;
  logic          busy;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  image_stream_tx #(
    .BitSize    (BW),
    .ImageWidth (IW)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .wr_full     (wr_full),
    .start       (start),
    .abort       (abort),
    .ready_in    (ready_in),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .result_done (result_done),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_pixels(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 32'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Streams a full frame with ready_in held high, checking every presented pixel.
  task automatic stream_all(input string tag, input logic [31:0] base);
    ready_in = 1'b1;
    for (int i = 0; i < int'(NP); i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, base + 32'(i));
      step();
    end
    ready_in = 1'b0;
    chk({tag, "_end_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_end_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;

    res_n = 1'b0; wr_en = 1'b0; wr_data = '0; start = 1'b0;
    abort = 1'b0; ready_in = 1'b0; result_done = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(wr_full), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    #10 res_n = 1'b1;
    step();

    // Full-rate stream, then a late result_done closes the frame.
    write_pixels(32'h10, 16);
    chk("t1_full", 32'(wr_full), 32'd1);
    pulse_start();
    stream_all("t1", 32'h10);
    pulse_start();
    chk("t1_start_busy_ignored", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) step();
    result_done = 1'b1;
    step();
    result_done = 1'b0;
    chk("t1_fdone", 32'(frame_done), 32'd1);
    chk("t1_full_clr", 32'(wr_full), 32'd0);
    chk("t1_busy_clr", 32'(busy), 32'd0);
    step();
    chk("t1_fdone_pulse", 32'(frame_done), 32'd0);

    // Alternating backpressure; result_done during streaming must not end the frame.
    write_pixels(32'h10, 16);
    pulse_start();
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 64) begin
      rdy = (cyc % 2 == 0);
      ready_in = rdy;
      result_done = (cyc == 1);
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_data", out_data, 32'h10 + 32'(idx));
      step();
      if (!rdy) begin
        chk("t2_hold_data", out_data, 32'h10 + 32'(idx));
        chk("t2_hold_valid", 32'(out_valid), 32'd1);
      end else begin
        idx++;
      end
      cyc++;
    end
    ready_in = 1'b0;
    result_done = 1'b0;
    chk("t2_count", 32'(idx), 32'd16);
    chk("t2_end_valid", 32'(out_valid), 32'd0);
    result_done = 1'b1;
    step();
    result_done = 1'b0;
    chk("t2_fdone", 32'(frame_done), 32'd1);

    // Start on a partial buffer is ignored; complete it and stream.
    write_pixels(32'h30, 10);
    pulse_start();
    chk("t3_nostart_valid", 32'(out_valid), 32'd0);
    chk("t3_nostart_busy", 32'(busy), 32'd0);
    chk("t3_part_full", 32'(wr_full), 32'd0);
    write_pixels(32'h3A, 6);
    chk("t3_full", 32'(wr_full), 32'd1);
    result_done = 1'b1;
    step();
    result_done = 1'b0;
    chk("t3_idle_rdone", 32'(frame_done), 32'd0);
    pulse_start();
    chk("t3_go_valid", 32'(out_valid), 32'd1);
    chk("t3_go_busy", 32'(busy), 32'd1);
    ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t3_data", out_data, 32'h30 + 32'(i));
      step();
    end
    ready_in = 1'b0;
    // Abort after the seventh transfer, colliding with start.
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("t4_abort_valid", 32'(out_valid), 32'd0);
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_full", 32'(wr_full), 32'd0);
    chk("t4_abort_fdone", 32'(frame_done), 32'd0);
    result_done = 1'b1;
    step();
    result_done = 1'b0;
    chk("t4_late_rdone", 32'(frame_done), 32'd0);
    pulse_start();
    chk("t4_start_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream, then reload with an extra write that must be dropped.
    write_pixels(32'h40, 16);
    pulse_start();
    ready_in = 1'b1;
    step();
    step();
    res_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", out_data, 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_full", 32'(wr_full), 32'd0);
    @(negedge clk);
    res_n = 1'b1;
    step();
    step();
    chk("t5_after_valid", 32'(out_valid), 32'd0);
    ready_in = 1'b0;
    write_pixels(32'h50, 16);
    chk("t5_full", 32'(wr_full), 32'd1);
    wr_en = 1'b1;
    wr_data = 32'hAA;
    step();
    wr_en = 1'b0;
    chk("t5_17th_full", 32'(wr_full), 32'd1);
    pulse_start();
    stream_all("t5", 32'h50);
    // Abort beats result_done in WAIT_DONE.
    abort = 1'b1;
    result_done = 1'b1;
    step();
    abort = 1'b0;
    result_done = 1'b0;
    chk("t5_abort_fdone", 32'(frame_done), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
